// File: rtl/branch_redirect_unit.sv
// ----------------------------------------------------------------------------
// branch_redirect_unit
//
// Purpose:
//   Takes the branch comparator outcome from EX and decides whether the PC is
//   redirected. On a taken branch or jump it computes the target and raises a
//   redirect request towards fetch one cycle later. It holds that request until
//   fetch acknowledges it. It pulses a one-cycle flush of IF/ID and ID/EX, and
//   stalls EX while the redirect is outstanding. Two saturating counters (all
//   resolved branches, taken branches) are kept for performance debug.
//
// Ports:
//   Clk           in   1      clock, all state on rising edge
//   Rst           in   1      asynchronous active-low reset
//   br_valid      in   1      EX holds a branch/jump this cycle
//   br_type       in   4      3=BGEZ 4=BEQ 5=BNE 6=BGTZ 7=BLEZ 8=BLTZ 9=J
//   comp_result   in   1      comparator outcome for br_type
//   pc_plus4      in   32     PC+4 of the branch instruction
//   imm16         in   16     branch offset in words
//   jidx          in   26     jump instruction index
//   redirect_ack  in   1      fetch accepted redirect_pc this cycle
//   cnt_clr       in   1      synchronous clear of both counters
//   redirect_vld  out  1      redirect request, held until ack
//   redirect_pc   out  32     new PC, stable while redirect_vld=1
//   flush         out  1      one-cycle kill of IF/ID and ID/EX
//   stall         out  1      hold EX/ID while a redirect is outstanding
//   branch_cnt    out  CNT_W  resolved branches/jumps (saturating)
//   taken_cnt     out  CNT_W  taken branches/jumps (saturating)
// ----------------------------------------------------------------------------
module branch_redirect_unit #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             br_valid,
  input  logic [3:0]       br_type,
  input  logic             comp_result,
  input  logic [31:0]      pc_plus4,
  input  logic [15:0]      imm16,
  input  logic [25:0]      jidx,
  input  logic             redirect_ack,
  input  logic             cnt_clr,
  output logic             redirect_vld,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             stall,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [3:0] BR_FIRST = 4'd3;
  localparam logic [3:0] BR_LAST  = 4'd9;
  localparam logic [3:0] BR_J     = 4'd9;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             is_br_s;
  logic             taken_s;
  logic             accept_s;
  logic [31:0]      target_s;
  logic             vld_r;
  logic [31:0]      pc_r;
  logic             flush_r;
  logic [CNT_W-1:0] branch_cnt_r;
  logic [CNT_W-1:0] taken_cnt_r;

  // Word offset sign-extended and scaled to bytes; wrap-around is silent.
  function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                input logic [15:0] off);
    return pc4 + {{14{off[15]}}, off, 2'b00};
  endfunction

  // Jump stays within the current 256 MB region of pc_plus4.
  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [25:0] idx);
    return {pc4[31:28], idx, 2'b00};
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    if (val == {CNT_W{1'b1}}) begin
      return val;
    end else begin
      return val + CNT_W'(1);
    end
  endfunction

  // Branch decode, taken decision and target selection.
  always_comb begin
    is_br_s  = br_valid && (br_type >= BR_FIRST) && (br_type <= BR_LAST);
    taken_s  = is_br_s && ((br_type == BR_J) || comp_result);
    // Branches are only sampled in IDLE; in WAIT upstream is stalled.
    accept_s = (state_r == ST_IDLE);
    if (br_type == BR_J) begin
      target_s = jump_target(pc_plus4, jidx);
    end else begin
      target_s = branch_target(pc_plus4, imm16);
    end
  end

  // Next-state logic for the redirect handshake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (taken_s) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (redirect_ack) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered redirect request, target and flush pulse.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      vld_r   <= 1'b0;
      pc_r    <= 32'h0000_0000;
      flush_r <= 1'b0;
    end else begin
      vld_r   <= (state_nxt_s == ST_WAIT);
      // Flush only on the IDLE->WAIT transition, so it lasts one cycle.
      flush_r <= accept_s && taken_s;
      if (accept_s && taken_s) begin
        pc_r <= target_s;
      end else begin
        pc_r <= pc_r;
      end
    end
  end

  // Saturating performance counters; clear wins over increment.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      branch_cnt_r <= '0;
      taken_cnt_r  <= '0;
    end else if (cnt_clr) begin
      branch_cnt_r <= '0;
      taken_cnt_r  <= '0;
    end else begin
      if (accept_s && is_br_s) begin
        branch_cnt_r <= sat_inc(branch_cnt_r);
      end else begin
        branch_cnt_r <= branch_cnt_r;
      end
      if (accept_s && taken_s) begin
        taken_cnt_r <= sat_inc(taken_cnt_r);
      end else begin
        taken_cnt_r <= taken_cnt_r;
      end
    end
  end

  assign redirect_vld = vld_r;
  assign redirect_pc  = pc_r;
  assign flush        = flush_r;
  assign stall        = (state_r == ST_WAIT);
  assign branch_cnt   = branch_cnt_r;
  assign taken_cnt    = taken_cnt_r;

endmodule
